// File: rtl/caxi4interconnect_decerr_slave_pkg.sv
// Shared encodings for the AXI4 default (DECERR) responder.
// AXI response codes and the write/read FSM state values.
package caxi4interconnect_decerr_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] WR_IDLE = 2'd0;
  localparam logic [1:0] WR_DATA = 2'd1;
  localparam logic [1:0] WR_RESP = 2'd2;

  localparam logic [0:0] RD_IDLE = 1'b0;
  localparam logic [0:0] RD_DATA = 1'b1;

endpackage

// File: rtl/caxi4interconnect_decerr_rd_chan.sv
// Read path of the DECERR responder: AR accept, beat counter, RID.
// Ports: clk/rst_n, AR inputs (arid, arlen, arvalid), arready, R handshake.
module caxi4interconnect_decerr_rd_chan
  import caxi4interconnect_decerr_slave_pkg::*;
#(
  parameter int ID_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ID_WIDTH-1:0] arid,
  input  logic [7:0]          arlen,
  input  logic                arvalid,
  output logic                arready,
  input  logic                rready,
  output logic                rvalid,
  output logic                rlast,
  output logic [ID_WIDTH-1:0] rid
);

  logic [0:0] rd_state;
  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= RD_IDLE;
      cnt      <= '0;
      rid      <= '0;
    end else begin
      unique case (rd_state)
        RD_IDLE: begin
          if (arvalid) begin
            rid      <= arid;
            cnt      <= arlen;
            rd_state <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rready) begin
            if (cnt != 8'd0) cnt <= cnt - 8'd1;
            else rd_state <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  // Outputs decode purely from registered state.
  assign arready = (rd_state == RD_IDLE);
  assign rvalid  = (rd_state == RD_DATA);
  assign rlast   = rvalid && (cnt == 8'd0);

endmodule

// File: rtl/caxi4interconnect_decerr_slave.sv
// AXI4 default responder: sinks unmapped bursts, answers RESP_CODE.
// Ports: ACLK/ARESETN, AW/W/B write path, AR/R read path (AXI4 names).
module caxi4interconnect_decerr_slave
  import caxi4interconnect_decerr_slave_pkg::*;
#(
  parameter int         ID_WIDTH   = 16,
  parameter int         DATA_WIDTH = 32,
  parameter int         USER_WIDTH = 1,
  parameter logic [1:0] RESP_CODE  = RESP_DECERR
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [ID_WIDTH-1:0]   AWID,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [ID_WIDTH-1:0]   BID,
  output logic [1:0]            BRESP,
  output logic [USER_WIDTH-1:0] BUSER,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ID_WIDTH-1:0]   ARID,
  input  logic [7:0]            ARLEN,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [ID_WIDTH-1:0]   RID,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic [USER_WIDTH-1:0] RUSER,
  output logic                  RVALID,
  input  logic                  RREADY
);

  logic [1:0] wr_state;

  // Write termination follows WLAST only; AWLEN is never consulted.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state <= WR_IDLE;
      BID      <= '0;
    end else begin
      unique case (wr_state)
        WR_IDLE: begin
          if (AWVALID) begin
            BID      <= AWID;
            wr_state <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (WVALID && WLAST) wr_state <= WR_RESP;
        end
        WR_RESP: begin
          if (BREADY) wr_state <= WR_IDLE;
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  assign AWREADY = (wr_state == WR_IDLE);
  assign WREADY  = (wr_state == WR_DATA);
  assign BVALID  = (wr_state == WR_RESP);
  assign BRESP   = RESP_CODE;
  assign BUSER   = '0;

  caxi4interconnect_decerr_rd_chan #(
    .ID_WIDTH(ID_WIDTH)
  ) u_rd_chan (
    .clk    (ACLK),
    .rst_n  (ARESETN),
    .arid   (ARID),
    .arlen  (ARLEN),
    .arvalid(ARVALID),
    .arready(ARREADY),
    .rready (RREADY),
    .rvalid (RVALID),
    .rlast  (RLAST),
    .rid    (RID)
  );

  assign RRESP = RESP_CODE;
  assign RDATA = '0;
  assign RUSER = '0;

endmodule

// File: tb/tb_caxi4interconnect_decerr_slave.sv
// Directed self-checking bench for the DECERR default responder.
// Drives inputs 1ns after rising edges, samples on falling edges.
module tb_caxi4interconnect_decerr_slave;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [15:0] AWID = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic        WLAST = 1'b0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [15:0] BID;
  logic [1:0]  BRESP;
  logic [0:0]  BUSER;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic [15:0] ARID = '0;
  logic [7:0]  ARLEN = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [15:0] RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic [0:0]  RUSER;
  logic        RVALID;
  logic        RREADY = 1'b0;

  int errs = 0;
  int checks = 0;

  caxi4interconnect_decerr_slave dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWID(AWID), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BUSER(BUSER),
    .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARLEN(ARLEN), .ARVALID(ARVALID),
    .ARREADY(ARREADY), .RID(RID), .RDATA(RDATA),
    .RRESP(RRESP), .RLAST(RLAST), .RUSER(RUSER),
    .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_awready"}, 32'(AWREADY), 32'd1);
    chk({p, "_arready"}, 32'(ARREADY), 32'd1);
    chk({p, "_wready"}, 32'(WREADY), 32'd0);
    chk({p, "_bvalid"}, 32'(BVALID), 32'd0);
    chk({p, "_rvalid"}, 32'(RVALID), 32'd0);
    chk({p, "_rlast"}, 32'(RLAST), 32'd0);
    chk({p, "_bid"}, 32'(BID), 32'd0);
    chk({p, "_rid"}, 32'(RID), 32'd0);
    chk({p, "_bresp"}, 32'(BRESP), 32'd3);
    chk({p, "_rresp"}, 32'(RRESP), 32'd3);
    chk({p, "_rdata"}, RDATA, 32'd0);
    chk({p, "_buser"}, 32'(BUSER), 32'd0);
    chk({p, "_ruser"}, 32'(RUSER), 32'd0);
  endtask

  initial begin
    int wb;
    int rb;
    int bad;
    int unstable;
    int bcnt;
    logic [15:0] bid_s;
    logic [15:0] rid_s;
    logic        done;
    logic        stall;
    logic [15:0] prid;
    logic        prlast;
    int          lastat;

    // Reset state
    #12;
    chk_reset_vals("rst");
    @(negedge ACLK);
    ARESETN = 1'b1;
    tick();

    // Write: AWID=0x5A, 4 beats
    AWID = 16'h5A;
    AWVALID = 1'b1;
    @(negedge ACLK);
    chk("w1_awready_pre", 32'(AWREADY), 32'd1);
    chk("w1_wready_pre", 32'(WREADY), 32'd0);
    tick();
    AWVALID = 1'b0;
    WVALID = 1'b1;
    wb = 0;
    for (int i = 0; i < 4; i++) begin
      WLAST = (i == 3);
      @(negedge ACLK);
      if (i == 0) chk("w1_awready_busy", 32'(AWREADY), 32'd0);
      if (WREADY) wb++;
      tick();
    end
    WVALID = 1'b0;
    WLAST = 1'b0;
    BREADY = 1'b1;
    @(negedge ACLK);
    chk("w1_beats", 32'(wb), 32'd4);
    chk("w1_wready_off", 32'(WREADY), 32'd0);
    chk("w1_bvalid", 32'(BVALID), 32'd1);
    chk("w1_bid", 32'(BID), 32'h5A);
    chk("w1_bresp", 32'(BRESP), 32'd3);
    tick();
    BREADY = 1'b0;
    @(negedge ACLK);
    chk("w1_awready_back", 32'(AWREADY), 32'd1);
    chk("w1_bvalid_off", 32'(BVALID), 32'd0);
    tick();

    // W before AW: held off
    WVALID = 1'b1;
    WLAST = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      if (WREADY) bad++;
      tick();
    end
    chk("w2_early_wready", 32'(bad), 32'd0);
    AWID = 16'h21;
    AWVALID = 1'b1;
    @(negedge ACLK);
    chk("w2_wready_aw_cyc", 32'(WREADY), 32'd0);
    tick();
    AWVALID = 1'b0;
    wb = 0;
    @(negedge ACLK);
    if (WREADY) wb++;
    tick();
    WVALID = 1'b0;
    WLAST = 1'b0;
    @(negedge ACLK);
    chk("w2_beats", 32'(wb), 32'd1);
    chk("w2_bvalid", 32'(BVALID), 32'd1);
    chk("w2_bid", 32'(BID), 32'h21);
    chk("w2_wready_off", 32'(WREADY), 32'd0);
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;

    // Read ARLEN=0
    ARID = 16'h3;
    ARLEN = 8'd0;
    ARVALID = 1'b1;
    @(negedge ACLK);
    chk("r1_rvalid_pre", 32'(RVALID), 32'd0);
    tick();
    ARVALID = 1'b0;
    RREADY = 1'b1;
    @(negedge ACLK);
    chk("r1_rvalid", 32'(RVALID), 32'd1);
    chk("r1_rlast", 32'(RLAST), 32'd1);
    chk("r1_rid", 32'(RID), 32'h3);
    chk("r1_rdata", RDATA, 32'd0);
    chk("r1_rresp", 32'(RRESP), 32'd3);
    chk("r1_arready_busy", 32'(ARREADY), 32'd0);
    tick();
    RREADY = 1'b0;
    @(negedge ACLK);
    chk("r1_rvalid_off", 32'(RVALID), 32'd0);
    chk("r1_arready_back", 32'(ARREADY), 32'd1);
    tick();

    // Read ARLEN=255 with RREADY toggling
    ARID = 16'h7;
    ARLEN = 8'd255;
    ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    rb = 0;
    bad = 0;
    unstable = 0;
    done = 1'b0;
    stall = 1'b0;
    prid = '0;
    prlast = 1'b0;
    for (int c = 0; c < 1200 && !done; c++) begin
      RREADY = (c % 2 == 0);
      @(negedge ACLK);
      if (stall && (RID !== prid || RLAST !== prlast || !RVALID))
        unstable++;
      if (RVALID) begin
        if (RLAST !== (rb == 255)) bad++;
        if (RID !== 16'h7) bad++;
        prid = RID;
        prlast = RLAST;
        stall = !RREADY;
        if (RREADY) begin
          rb++;
          if (RLAST) done = 1'b1;
        end
      end
      tick();
    end
    RREADY = 1'b0;
    chk("r256_done", 32'(done), 32'd1);
    chk("r256_beats", 32'(rb), 32'd256);
    chk("r256_rlast_rid", 32'(bad), 32'd0);
    chk("r256_stall_stable", 32'(unstable), 32'd0);
    @(negedge ACLK);
    chk("r256_idle", 32'(RVALID), 32'd0);
    tick();

    // Concurrent write (8 beats) and read (ARLEN=7)
    AWID = 16'h44;
    AWVALID = 1'b1;
    ARID = 16'h9;
    ARLEN = 8'd7;
    ARVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    ARVALID = 1'b0;
    WVALID = 1'b1;
    WLAST = 1'b0;
    RREADY = 1'b1;
    BREADY = 1'b1;
    wb = 0;
    rb = 0;
    bcnt = 0;
    bid_s = '0;
    rid_s = '0;
    lastat = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge ACLK);
      if (WVALID && WREADY) wb++;
      if (BVALID) begin
        bcnt++;
        bid_s = BID;
      end
      if (RVALID) begin
        rb++;
        rid_s = RID;
        if (RLAST && lastat == 0) lastat = rb;
      end
      tick();
      WVALID = (wb < 8);
      WLAST = (wb == 7);
    end
    RREADY = 1'b0;
    BREADY = 1'b0;
    chk("cc_wbeats", 32'(wb), 32'd8);
    chk("cc_bcount", 32'(bcnt), 32'd1);
    chk("cc_bid", 32'(bid_s), 32'h44);
    chk("cc_rbeats", 32'(rb), 32'd8);
    chk("cc_rid", 32'(rid_s), 32'h9);
    chk("cc_rlast_at", 32'(lastat), 32'd8);

    // Reset mid-burst
    AWID = 16'h11;
    AWVALID = 1'b1;
    ARID = 16'h15;
    ARLEN = 8'd7;
    ARVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    ARVALID = 1'b0;
    WVALID = 1'b1;
    WLAST = 1'b0;
    RREADY = 1'b1;
    tick();
    tick();
    @(negedge ACLK);
    chk("mr_rvalid_pre", 32'(RVALID), 32'd1);
    chk("mr_wready_pre", 32'(WREADY), 32'd1);
    #1;
    ARESETN = 1'b0;
    #1;
    chk_reset_vals("mr");
    WVALID = 1'b0;
    RREADY = 1'b0;
    @(negedge ACLK);
    ARESETN = 1'b1;
    tick();
    ARID = 16'h2A;
    ARLEN = 8'd7;
    ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    RREADY = 1'b1;
    rb = 0;
    bcnt = 0;
    done = 1'b0;
    rid_s = '0;
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge ACLK);
      if (BVALID) bcnt++;
      if (RVALID) begin
        rb++;
        rid_s = RID;
        if (RLAST) done = 1'b1;
      end
      tick();
    end
    RREADY = 1'b0;
    chk("mr_new_done", 32'(done), 32'd1);
    chk("mr_new_beats", 32'(rb), 32'd8);
    chk("mr_new_rid", 32'(rid_s), 32'h2A);
    chk("mr_no_bresp", 32'(bcnt), 32'd0);
    chk("mr_awready", 32'(AWREADY), 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
